// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU: fetch FSM encoding, bubble word,
// instruction field positions and control-flow opcodes.
package cpu_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INSTR = 32'hFF00_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int OFFSET_MSB = 23;
    localparam int OFFSET_LSB = 16;
    localparam int RD_MSB     = 23;
    localparam int RD_LSB     = 16;
    localparam int RT_MSB     = 15;
    localparam int RT_LSB     = 8;
    localparam int RS_MSB     = 7;
    localparam int RS_LSB     = 0;

    localparam logic [7:0] OP_JUMP = 8'h06;
    localparam logic [7:0] OP_BEQ  = 8'h07;
    localparam logic [7:0] OP_BNE  = 8'h0C;

    // Packs the four byte fields into an instruction word.
    function automatic logic [31:0] make_instr(input logic [7:0] opcode,
                                               input logic [7:0] rd_offset,
                                               input logic [7:0] rt,
                                               input logic [7:0] rs_imm);
        logic [31:0] word;
        word = '0;
        word[OPCODE_MSB:OPCODE_LSB] = opcode;
        word[RD_MSB:RD_LSB]         = rd_offset;
        word[RT_MSB:RT_LSB]         = rt;
        word[RS_MSB:RS_LSB]         = rs_imm;
        return word;
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Computes the sequential PC and the PC-relative target (offset counts words).
module pc_target_adder (
    input  logic [31:0] pc,
    input  logic [7:0]  offset,
    output logic [31:0] pc4,
    output logic [31:0] tgt
);

    logic [31:0] offs;

    // Sign-extended word offset; the two zero LSBs keep targets word-aligned.
    assign offs = {{22{offset[7]}}, offset, 2'b00};
    assign pc4  = pc + 32'd4;
    assign tgt  = pc4 + offs;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, fetches from the instruction cache and feeds control_unit,
// substituting a bubble word whenever no fetched instruction is executing.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = cpu_pkg::BUBBLE_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_BUSYWAIT,
    input  logic [31:0] I_READDATA,
    input  logic        D_BUSYWAIT,
    input  logic        JUMP,
    input  logic        BRANCHEQ,
    input  logic        BRANCHNE,
    input  logic        ZERO,
    output logic        I_READ,
    output logic [31:0] I_ADDRESS,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID
);

    import cpu_pkg::*;

    fetch_state_t state, next_state;
    logic [31:0]  pc;
    logic [31:0]  ir;
    logic [31:0]  pc4;
    logic [31:0]  tgt;
    logic [31:0]  next_pc;
    logic         take_tgt;
    logic         load_ir;
    logic         retire;

    pc_target_adder u_pc_target_adder (
        .pc     (pc),
        .offset (ir[OFFSET_MSB:OFFSET_LSB]),
        .pc4    (pc4),
        .tgt    (tgt)
    );

    // Every taken form (jump, beq, bne) selects the same target, so JUMP
    // priority holds trivially.
    assign take_tgt = JUMP | (BRANCHEQ & ZERO) | (BRANCHNE & ~ZERO);
    assign next_pc  = take_tgt ? tgt : pc4;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        I_READ      = 1'b0;
        INSTR_VALID = 1'b0;
        INSTRUCTION = BUBBLE_INSTR;
        load_ir     = 1'b0;
        retire      = 1'b0;
        unique case (state)
            S_FETCH: begin
                I_READ  = ~RESET;
                load_ir = ~I_BUSYWAIT;
                if (!I_BUSYWAIT) next_state = S_EXEC;
            end
            S_EXEC: begin
                INSTR_VALID = 1'b1;
                INSTRUCTION = ir;
                retire      = ~D_BUSYWAIT;
                if (!D_BUSYWAIT) next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_FETCH;
            pc    <= RESET_VECTOR;
            ir    <= BUBBLE_INSTR;
        end else begin
            state <= next_state;
            if (load_ir) ir <= I_READDATA;
            if (retire) begin
                pc <= next_pc;
                ir <= BUBBLE_INSTR;
            end
        end
    end

    assign I_ADDRESS = pc;

endmodule
